// File: rtl/subleq_fetch.sv
// subleq_fetch: fetches the three operands (A, B, C) of a SUBLEQ instruction
// from consecutive memory words starting at pc. It issues one read per
// operand and waits for mem_ack. If the ack wait for an operand reaches
// TIMEOUT cycles, the fetch aborts with a one-cycle err pulse.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-low reset
//   start      fetch request, sampled only while idle
//   pc         word address of operand A
//   mem_req    memory read request
//   mem_addr   memory read word address (0 when not requesting)
//   mem_ack    read data valid on mem_rdata this cycle
//   mem_rdata  memory read data
//   a, b, c    fetched operands
//   busy       high whenever the fetcher is not idle
//   done       one-cycle pulse when a, b and c are all valid
//   err        one-cycle pulse on timeout abort
//
// All outputs are registered. Each output register is loaded with the
// decode of the next state, so the outputs always match the current state.

module subleq_fetch #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] pc,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic [63:0] a,
  output logic [63:0] b,
  output logic [63:0] c,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ_A = 3'd1,
    ST_REQ_B = 3'd2,
    ST_REQ_C = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_base;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [DW-1:0] r_c;
  logic          r_mem_req;
  logic [AW-1:0] r_mem_addr;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  state_t        w_state_nxt;
  logic [AW-1:0] w_base_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [DW-1:0] w_a_nxt;
  logic [DW-1:0] w_b_nxt;
  logic [DW-1:0] w_c_nxt;
  logic          w_mem_req_nxt;
  logic [AW-1:0] w_mem_addr_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic          w_err_nxt;
  logic          w_last_wait;

  // This cycle is the TIMEOUT-th consecutive cycle without an ack.
  assign w_last_wait = (r_cnt == CW'(TIMEOUT - 32'd1));

  // Next-state, operand capture, wait counter and output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_base_nxt     = r_base;
    w_cnt_nxt      = r_cnt;
    w_a_nxt        = r_a;
    w_b_nxt        = r_b;
    w_c_nxt        = r_c;
    w_err_nxt      = 1'b0;
    w_mem_req_nxt  = 1'b0;
    w_mem_addr_nxt = '0;
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_base_nxt  = pc;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_REQ_A;
        end
      end
      ST_REQ_A: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (mem_ack) begin
          w_a_nxt     = mem_rdata;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_REQ_B;
        end else if (w_last_wait) begin
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      ST_REQ_B: begin
        if (mem_ack) begin
          w_b_nxt     = mem_rdata;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_REQ_C;
        end else if (w_last_wait) begin
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      ST_REQ_C: begin
        if (mem_ack) begin
          w_c_nxt     = mem_rdata;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_DONE;
        end else if (w_last_wait) begin
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Outputs follow the state being entered; addresses wrap modulo 2^64.
    case (w_state_nxt)
      ST_REQ_A: begin
        w_mem_req_nxt  = 1'b1;
        w_mem_addr_nxt = w_base_nxt;
      end
      ST_REQ_B: begin
        w_mem_req_nxt  = 1'b1;
        w_mem_addr_nxt = w_base_nxt + AW'(1);
      end
      ST_REQ_C: begin
        w_mem_req_nxt  = 1'b1;
        w_mem_addr_nxt = w_base_nxt + AW'(2);
      end
      default: begin
        w_mem_req_nxt  = 1'b0;
        w_mem_addr_nxt = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  // State and output registers; reset drops any in-flight ack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_base     <= w_base_nxt;
      r_cnt      <= w_cnt_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_c        <= w_c_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign a        = r_a;
  assign b        = r_b;
  assign c        = r_c;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_subleq_fetch.sv
// Directed testbench for subleq_fetch (instantiated with TIMEOUT=4).
module tb_subleq_fetch;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] pc;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] c;
  logic        busy;
  logic        done;
  logic        err;

  int vectors;
  int miscompares;

  subleq_fetch #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pc        (pc),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .a         (a),
    .b         (b),
    .c         (c),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Memory contents: a few fixed words, otherwise address xor a marker.
  function automatic logic [63:0] mem_word(input logic [63:0] ad);
    case (ad)
      64'h10:  mem_word = 64'd5;
      64'h11:  mem_word = 64'd7;
      64'h12:  mem_word = 64'h40;
      default: mem_word = ad ^ 64'hA5A5_0000_0000_0000;
    endcase
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b0;
    start   = 1'b0;
    pc      = '0;
    mem_ack = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_addr",    mem_addr,     64'd0);
    chk("rst_busy",    64'(busy),    64'd0);
    chk("rst_done",    64'(done),    64'd0);
    chk("rst_err",     64'(err),     64'd0);
    chk("rst_a", a, 64'd0);
    chk("rst_b", b, 64'd0);
    chk("rst_c", c, 64'd0);

    // Back-to-back acks at pc=0x10
    rst = 1'b1;
    step();
    pc = 64'h10; start = 1'b1; mem_ack = 1'b1;
    step();
    start = 1'b0;
    chk("t1_req",   64'(mem_req), 64'd1);
    chk("t1_addrA", mem_addr, 64'h10);
    chk("t1_busy",  64'(busy), 64'd1);
    step();
    chk("t1_a",     a, 64'd5);
    chk("t1_addrB", mem_addr, 64'h11);
    step();
    chk("t1_b",     b, 64'd7);
    chk("t1_addrC", mem_addr, 64'h12);
    chk("t1_done0", 64'(done), 64'd0);
    step();
    chk("t1_c",     c, 64'h40);
    chk("t1_done",  64'(done), 64'd1);
    chk("t1_dreq",  64'(mem_req), 64'd0);
    chk("t1_daddr", mem_addr, 64'd0);
    step();
    chk("t1_done_end", 64'(done), 64'd0);
    chk("t1_idle",     64'(busy), 64'd0);
    step();
    chk("t1_a_hold",   a, 64'd5);
    chk("t1_idle_req", 64'(mem_req), 64'd0);

    // Ack delayed 3 cycles per operand at pc=0x100
    mem_ack = 1'b0; pc = 64'h100; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 3; w++) begin
        step();
        chk("t2_addr_hold", mem_addr, 64'h100 + 64'(k));
        chk("t2_no_err", 64'(err), 64'd0);
        chk("t2_no_done", 64'(done), 64'd0);
      end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
    end
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_err",  64'(err),  64'd0);
    chk("t2_a", a, 64'hA5A5_0000_0000_0100);
    chk("t2_b", b, 64'hA5A5_0000_0000_0101);
    chk("t2_c", c, 64'hA5A5_0000_0000_0102);
    step();
    chk("t2_done_end", 64'(done), 64'd0);

    // Address wrap at the top of memory
    pc = 64'hFFFF_FFFF_FFFF_FFFE; start = 1'b1; mem_ack = 1'b1;
    step();
    start = 1'b0;
    chk("t3_addrA", mem_addr, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    chk("t3_addrB", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    chk("t3_addrC", mem_addr, 64'h0);
    step();
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_a", a, 64'h5A5A_FFFF_FFFF_FFFE);
    chk("t3_b", b, 64'h5A5A_FFFF_FFFF_FFFF);
    chk("t3_c", c, 64'hA5A5_0000_0000_0000);
    step();

    // Timeout in REQ_B after A was captured
    pc = 64'h200; start = 1'b1; mem_ack = 1'b0;
    step();
    start = 1'b0; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t4_a", a, 64'hA5A5_0000_0000_0200);
    chk("t4_addrB", mem_addr, 64'h201);
    for (int w = 0; w < 3; w++) begin
      step();
      chk("t4_wait_req", 64'(mem_req), 64'd1);
      chk("t4_wait_err", 64'(err), 64'd0);
    end
    step();
    chk("t4_err",  64'(err),     64'd1);
    chk("t4_req",  64'(mem_req), 64'd0);
    chk("t4_busy", 64'(busy),    64'd0);
    chk("t4_done", 64'(done),    64'd0);
    chk("t4_addr", mem_addr, 64'd0);
    chk("t4_a_kept", a, 64'hA5A5_0000_0000_0200);
    chk("t4_b_kept", b, 64'h5A5A_FFFF_FFFF_FFFF);
    chk("t4_c_kept", c, 64'hA5A5_0000_0000_0000);
    step();
    chk("t4_err_end", 64'(err), 64'd0);
    chk("t4_no_done", 64'(done), 64'd0);

    // Reset mid-fetch while in REQ_B with ack high
    pc = 64'h300; start = 1'b1; mem_ack = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t5_a", a, 64'hA5A5_0000_0000_0300);
    rst = 1'b0;
    step();
    chk("t5_req",  64'(mem_req), 64'd0);
    chk("t5_addr", mem_addr, 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_err",  64'(err),  64'd0);
    chk("t5_a0", a, 64'd0);
    chk("t5_b0", b, 64'd0);
    rst = 1'b1; pc = 64'h10; start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_restart_busy", 64'(busy), 64'd1);
    chk("t5_restart_addr", mem_addr, 64'h10);
    step();
    step();
    step();
    chk("t5_done2", 64'(done), 64'd1);
    chk("t5_a2", a, 64'd5);
    chk("t5_b2", b, 64'd7);
    chk("t5_c2", c, 64'h40);
    step();

    // Start held high: next fetch only after the return to IDLE
    pc = 64'h10; start = 1'b1; mem_ack = 1'b1;
    step();
    chk("t6_busy", 64'(busy), 64'd1);
    pc = 64'h500;
    step();
    chk("t6_addrB", mem_addr, 64'h11);
    step();
    chk("t6_addrC", mem_addr, 64'h12);
    step();
    chk("t6_done", 64'(done), 64'd1);
    step();
    chk("t6_idle", 64'(busy), 64'd0);
    chk("t6_idle_req", 64'(mem_req), 64'd0);
    step();
    chk("t6_second", 64'(busy), 64'd1);
    chk("t6_second_addr", mem_addr, 64'h500);
    start = 1'b0; pc = 64'h10;
    step();
    chk("t6_base_kept", mem_addr, 64'h501);
    step();
    step();
    chk("t6_done2", 64'(done), 64'd1);
    chk("t6_c2", c, 64'hA5A5_0000_0000_0502);
    step();
    chk("t6_end_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
